// File: rtl/aes_spi_pkg.sv
// Shared constants, job frame layout and FSM state encoding for the AES SPI host.
package aes_spi_pkg;

  localparam int FRAME_TX_BYTES = 49;
  localparam int FRAME_RX_BYTES = 17;
  localparam int RX_DISCARD     = 1;

  localparam logic [1:0] KEYLEN_128     = 2'd0;
  localparam logic [1:0] KEYLEN_192     = 2'd1;
  localparam logic [1:0] KEYLEN_256     = 2'd2;
  localparam logic [1:0] KEYLEN_ILLEGAL = 2'd3;

  localparam logic [7:0] PARAM_128 = 8'h10;
  localparam logic [7:0] PARAM_192 = 8'h18;
  localparam logic [7:0] PARAM_256 = 8'h20;

  // Write-phase frame, first member goes out on the wire first.
  typedef struct packed {
    logic [127:0] block;
    logic [7:0]   param;
    logic [255:0] key;
  } job_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_SETUP,
    ST_XFER,
    ST_GAP,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } host_state_t;

  function automatic logic [7:0] param_byte(input logic [1:0] key_len);
    case (key_len)
      KEYLEN_128: return PARAM_128;
      KEYLEN_192: return PARAM_192;
      default:    return PARAM_256;
    endcase
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_byte_master.sv
// One mode-0 full-duplex byte: 16 half-periods of CLK_DIV clk from the go cycle, done pulses
// in the cycle after the last falling edge; go is ignored while a byte is in flight.
module spi_byte_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] tx_byte,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic             active;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sh;
  logic [7:0]       rx_sh;
  logic             half_end;

  assign half_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign mosi     = tx_sh[7];
  assign rx_byte  = rx_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      sclk    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go && !active) begin
        // The go cycle is the first clk of the leading low half-period.
        active  <= 1'b1;
        div_cnt <= DIV_W'(1);
        bit_cnt <= '0;
        tx_sh   <= tx_byte;
        sclk    <= 1'b0;
      end else if (active) begin
        if (half_end) begin
          div_cnt <= '0;
          sclk    <= ~sclk;
          if (!sclk) begin
            rx_sh <= {rx_sh[6:0], miso};
          end else if (bit_cnt == 3'd7) begin
            active <= 1'b0;
            done   <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sh   <= {tx_sh[6:0], 1'b0};
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_spi_host.sv
// Frames one AES decrypt job over SPI (49 B out, 17 B back, last 16 kept); fixed latency set by
// the timing parameters; start is ignored while busy, key_len=3 answers with a one-cycle error.
module aes_spi_host
  import aes_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int BYTE_GAP  = 8,
  parameter int CS_SETUP  = 4,
  parameter int RESP_WAIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [127:0] block_in,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic [127:0] result_out,
  output logic         result_valid,
  output logic         error,
  output logic         sclk,
  output logic         cs_n,
  output logic         mosi,
  input  logic         miso
);

  localparam int JOB_BITS = $bits(job_t);
  localparam int WAIT_W   = $clog2(max3(CS_SETUP, BYTE_GAP, RESP_WAIT) + 1);

  localparam logic [6:0] TX_LAST  = 7'(FRAME_TX_BYTES - 1);
  localparam logic [6:0] RX_FIRST = 7'(FRAME_TX_BYTES + RX_DISCARD);
  localparam logic [6:0] RX_LAST  = 7'(FRAME_TX_BYTES + FRAME_RX_BYTES - 1);

  localparam logic [WAIT_W-1:0] SETUP_END = WAIT_W'(CS_SETUP - 1);
  localparam logic [WAIT_W-1:0] GAP_END   = WAIT_W'(BYTE_GAP - 1);
  localparam logic [WAIT_W-1:0] RESP_END  = WAIT_W'(RESP_WAIT - 1);

  host_state_t         state;
  logic [JOB_BITS-1:0] frame;
  logic [127:0]        rx_sh;
  logic [6:0]          byte_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                byte_go;
  logic                byte_done;
  logic [7:0]          rx_byte;

  spi_byte_master #(
    .CLK_DIV (CLK_DIV)
  ) u_byte (
    .clk     (clk),
    .reset   (reset),
    .go      (byte_go),
    .tx_byte (frame[JOB_BITS-1 -: 8]),
    .rx_byte (rx_byte),
    .done    (byte_done),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      frame        <= '0;
      rx_sh        <= '0;
      byte_cnt     <= '0;
      wait_cnt     <= '0;
      byte_go      <= 1'b0;
      busy         <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      cs_n         <= 1'b1;
    end else begin
      byte_go      <= 1'b0;
      result_valid <= 1'b0;
      error        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (key_len == KEYLEN_ILLEGAL) begin
              error <= 1'b1;
              state <= ST_ERR;
            end else begin
              frame    <= job_t'{block: block_in, param: param_byte(key_len), key: key_in};
              byte_cnt <= '0;
              wait_cnt <= '0;
              busy     <= 1'b1;
              cs_n     <= 1'b0;
              state    <= ST_SETUP;
            end
          end
        end
        ST_ERR: state <= ST_IDLE;
        ST_SETUP: begin
          if (wait_cnt >= SETUP_END) begin
            byte_go <= 1'b1;
            state   <= ST_XFER;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_XFER: begin
          if (byte_done) begin
            frame <= {frame[JOB_BITS-9:0], 8'h00};
            if (byte_cnt >= RX_FIRST) rx_sh <= {rx_sh[119:0], rx_byte};
            // The done cycle already has sclk low, so it counts as the first idle cycle.
            wait_cnt <= WAIT_W'(1);
            if (byte_cnt == TX_LAST) begin
              state <= ST_WAIT;
            end else if (byte_cnt == RX_LAST) begin
              state <= ST_HOLD;
            end else begin
              state <= ST_GAP;
            end
            if (byte_cnt != RX_LAST) byte_cnt <= byte_cnt + 7'd1;
          end
        end
        ST_GAP: begin
          if (wait_cnt >= GAP_END) begin
            byte_go <= 1'b1;
            state   <= ST_XFER;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WAIT: begin
          if (wait_cnt >= RESP_END) begin
            byte_go <= 1'b1;
            state   <= ST_XFER;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (wait_cnt >= SETUP_END) begin
            cs_n  <= 1'b1;
            state <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          result_out   <= rx_sh;
          result_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
